// File: rtl/scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scan_ctrl
// Purpose  : Scan-chain sequencer. Each accepted start shifts a pattern into
//            the DUT chain, grants a programmable number of functional
//            cycles, then shifts the chain out into a capture register.
// Revision : 1.0  initial release
// ============================================================================
module scan_ctrl #(
    parameter int CHAIN_LEN = 16,
    parameter int RUN_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [RUN_W-1:0]     run_cycles,
    input  logic                 sout,
    output logic                 sin,
    output logic                 sen,
    output logic                 scan_ce,
    output logic                 func_en,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] result
);

    localparam int               c_cnt_w    = $clog2(CHAIN_LEN) + 1;
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHIFT_IN  = 3'd1,
        ST_RUN       = 3'd2,
        ST_SHIFT_OUT = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_bit_cnt;
    logic [RUN_W-1:0]     r_run_cnt;   // holds latched run_cycles, counts down in RUN
    logic [CHAIN_LEN-1:0] r_pattern;
    logic [CHAIN_LEN-1:0] r_cap;
    logic [CHAIN_LEN-1:0] r_result;
    logic                 w_pat_bit;

    // Pattern bit for the current shift-in cycle; bit 0 enters the chain first
    assign w_pat_bit = r_pattern[r_bit_cnt[c_cnt_w-2:0]];

    // Scan pins and status are decoded from registered state/counter only
    assign sen     = (r_state == ST_SHIFT_IN) || (r_state == ST_SHIFT_OUT);
    assign scan_ce = sen;
    assign sin     = (r_state == ST_SHIFT_IN) && w_pat_bit;
    assign func_en = (r_state == ST_RUN);
    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_DONE);
    assign result  = r_result;

    // Phase sequencer with operand latching and sout capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_run_cnt <= '0;
            r_pattern <= '0;
            r_cap     <= '0;
            r_result  <= '0;
        end else if (abort && (r_state != ST_IDLE)) begin
            // Abort drops the run without touching the last good result
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_pattern <= pattern;
                        r_run_cnt <= run_cycles;
                        r_bit_cnt <= '0;
                        r_state   <= ST_SHIFT_IN;
                    end
                end
                ST_SHIFT_IN: begin
                    if (r_bit_cnt == c_last_bit) begin
                        r_bit_cnt <= '0;
                        r_state   <= (r_run_cnt != '0) ? ST_RUN : ST_SHIFT_OUT;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + c_cnt_w'(1);
                    end
                end
                ST_RUN: begin
                    // Count down; the cycle holding 1 is the last functional cycle
                    if (r_run_cnt == RUN_W'(1)) begin
                        r_run_cnt <= '0;
                        r_state   <= ST_SHIFT_OUT;
                    end else begin
                        r_run_cnt <= r_run_cnt - RUN_W'(1);
                    end
                end
                ST_SHIFT_OUT: begin
                    // sout is the pre-edge last-flop value; it enters from the top
                    r_cap <= {sout, r_cap[CHAIN_LEN-1:1]};
                    if (r_bit_cnt == c_last_bit) begin
                        r_result <= {sout, r_cap[CHAIN_LEN-1:1]};
                        r_state  <= ST_DONE;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + c_cnt_w'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_ctrl
// Purpose  : Self-checking bench for scan_ctrl with a two-ScanReg8 chain model
// Revision : 1.0  initial release
// ============================================================================
module tb_scan_ctrl;

    localparam int N  = 16;
    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          reset, start, abort, sout;
    logic          sin, sen, scan_ce, func_en, busy, done;
    logic [N-1:0]  pattern, result;
    logic [RW-1:0] run_cycles;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        logic [N-1:0] res;
        int           cyc;
    } exp_t;
    exp_t sb_q[$];

    // Chain model: sin -> in_reg[0..7] -> out_reg[0..7] -> sout
    logic [7:0] in_reg  = 8'h00;
    logic [7:0] out_reg = 8'h00;
    logic       dp_mode = 1'b0;
    logic       func_seen = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign sout = out_reg[7];

    // DUT-side scan register pair; functional mode: out_reg <= in_reg + 1
    always @(posedge clk) begin
        if (sen && scan_ce) begin
            in_reg  <= {in_reg[6:0], sin};
            out_reg <= {out_reg[6:0], in_reg[7]};
        end else if (dp_mode && func_en) begin
            out_reg <= in_reg + 8'd1;
        end
    end

    scan_ctrl #(.CHAIN_LEN(N), .RUN_W(RW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .pattern    (pattern),
        .run_cycles (run_cycles),
        .sout       (sout),
        .sin        (sin),
        .sen        (sen),
        .scan_ce    (scan_ce),
        .func_en    (func_en),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] rev16(input logic [N-1:0] v);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = v[N-1-i];
        return r;
    endfunction

    // Reference result: position p of the chain ends up in result bit N-1-p
    function automatic logic [N-1:0] model_result(input logic [N-1:0] pat, input int runs, input logic dp);
        logic [N-1:0] pos;
        pos = rev16(pat);
        if (dp && runs > 0) pos[15:8] = pos[7:0] + 8'd1;
        return rev16(pos);
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (func_en) func_seen = 1'b1;
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", done, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    check("result", result, e.res);
                    check("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Drive a start at the next falling edge; expectation is pushed if accepted
    task automatic do_start(input logic [N-1:0] pat, input logic [RW-1:0] runs, input logic expect_accept);
        exp_t e;
        @(negedge clk);
        start      = 1'b1;
        pattern    = pat;
        run_cycles = runs;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (expect_accept) begin
            e.res = model_result(pat, int'(runs), dp_mode);
            e.cyc = cyc + 2 * N + int'(runs);
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int max_cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_timeout", seen, 1'b1);
    endtask

    initial begin
        logic [N-1:0] rv;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        pattern = '0; run_cycles = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_sen", sen, 1'b0);
        check("rst_scan_ce", scan_ce, 1'b0);
        check("rst_sin", sin, 1'b0);
        check("rst_func_en", func_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 16'h0000);

        // Round trip, no functional cycles
        func_seen = 1'b0;
        do_start(16'hA5C3, 8'd0, 1'b1);
        wait_done(60);
        check("rt_func_en_never", func_seen, 1'b0);

        // Run phase: func_en and sen windows cycle by cycle
        do_start(16'h00FF, 8'd4, 1'b1);
        for (int c = 1; c <= 2 * N + 4 + 1; c++) begin
            @(negedge clk);
            check($sformatf("run_func_en_c%0d", c), func_en, (c >= 17 && c <= 20));
            check($sformatf("run_sen_c%0d", c), sen, ((c >= 1 && c <= 16) || (c >= 21 && c <= 36)));
        end

        // Datapath: inputreg=0x10, one increment cycle into outputreg
        dp_mode = 1'b1;
        do_start(rev16({8'h00, 8'h10}), 8'd1, 1'b1);
        wait_done(60);
        rv = rev16(result);
        check("dp_outreg", rv[15:8], 8'h11);
        check("dp_inreg", rv[7:0], 8'h10);
        dp_mode = 1'b0;

        // Start while busy is ignored; start right after DONE is accepted
        do_start(16'h3C5A, 8'd0, 1'b1);
        repeat (4) @(negedge clk);
        do_start(16'hFFFF, 8'd3, 1'b0);
        wait_done(60);
        do_start(16'h1234, 8'd2, 1'b1);
        check("restart_busy", busy, 1'b1);
        wait_done(60);

        // Abort in SHIFT_IN cycle 5
        do_start(16'hFFFF, 8'd0, 1'b1);
        repeat (4) @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        void'(sb_q.pop_back());
        @(negedge clk);
        check("abort_sen", sen, 1'b0);
        check("abort_busy", busy, 1'b0);
        repeat (40) @(negedge clk);
        check("abort_result", result, 16'h1234);

        // Reset held two cycles mid-SHIFT_OUT
        do_start(16'hA5C3, 8'd0, 1'b1);
        repeat (19) @(negedge clk);
        check("pre_rst_sen", sen, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1 void'(sb_q.pop_back());
        @(negedge clk);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_sen", sen, 1'b0);
        check("mid_rst_scan_ce", scan_ce, 1'b0);
        check("mid_rst_sin", sin, 1'b0);
        check("mid_rst_result", result, 16'h0000);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (40) @(negedge clk);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_result", result, 16'h0000);
        check("sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
